// File: rtl/neopixel_rx.sv
// WS2812-style single-wire receiver: classifies high pulses by width into bits,
// assembles LSB-first 24-bit colour words and addresses them within a frame.
module neopixel_rx #(
    parameter int NUM_LEDS     = 16,
    parameter int MIN_HIGH     = 4,
    parameter int THRESH       = 15,
    parameter int MAX_HIGH     = 40,
    parameter int RESET_CYCLES = 1250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    output logic [23:0] color,
    output logic [15:0] address,
    output logic        color_valid,
    output logic        frame_done,
    output logic        error,
    output logic        overflow,
    output logic        busy
);
    localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
    localparam int HIGH_W = $clog2(MAX_HIGH + 2);

    localparam logic [LOW_W-1:0]  GAP_LAST = LOW_W'(RESET_CYCLES - 1);
    localparam logic [LOW_W-1:0]  GAP_SAT  = LOW_W'(RESET_CYCLES);
    localparam logic [HIGH_W-1:0] MIN_H    = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] THRESH_H = HIGH_W'(THRESH);
    localparam logic [HIGH_W-1:0] MAX_H    = HIGH_W'(MAX_HIGH);
    localparam logic [16:0]       LEDS_W   = 17'(NUM_LEDS);

    typedef enum logic [1:0] {S_SYNC, S_LOW, S_HIGH} state_t;

    state_t              state;
    logic                din_p0;
    logic                s;
    logic                s_prev;
    logic [LOW_W-1:0]    low_cnt;
    logic [HIGH_W-1:0]   high_cnt;
    logic [23:0]         shift;
    logic [4:0]          bit_idx;
    logic [15:0]         word_idx;
    logic                got_bit;
    logic                gap_seen;
    logic                rise;
    logic                fall;
    logic                bit_val;

    function automatic logic decode_bit(input logic [HIGH_W-1:0] width);
        return width >= THRESH_H;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rise    = s & ~s_prev;
    assign fall    = ~s & s_prev;
    assign bit_val = decode_bit(high_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_p0      <= 1'b0;
            s           <= 1'b0;
            s_prev      <= 1'b0;
            state       <= S_SYNC;
            low_cnt     <= '0;
            high_cnt    <= '0;
            shift       <= '0;
            bit_idx     <= '0;
            word_idx    <= '0;
            got_bit     <= 1'b0;
            gap_seen    <= 1'b0;
            color       <= '0;
            address     <= '0;
            color_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // synchroniser stage boundary: din -> din_p0 -> s -> s_prev
            din_p0      <= din;
            s           <= din_p0;
            s_prev      <= s;
            color_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;

            case (state)
                S_SYNC: begin
                    if (s) begin
                        low_cnt <= '0;
                    end else if (low_cnt == GAP_LAST) begin
                        low_cnt  <= GAP_SAT;
                        state    <= S_LOW;
                        busy     <= 1'b0;
                        word_idx <= '0;
                        bit_idx  <= '0;
                        got_bit  <= 1'b0;
                        gap_seen <= 1'b1;
                    end else begin
                        low_cnt <= low_cnt + LOW_W'(1);
                    end
                end

                S_LOW: begin
                    if (rise) begin
                        state    <= S_HIGH;
                        high_cnt <= HIGH_W'(1);
                        busy     <= 1'b1;
                        low_cnt  <= '0;
                        if (gap_seen) begin
                            overflow <= 1'b0;
                            gap_seen <= 1'b0;
                        end
                    end else if (low_cnt == GAP_LAST) begin
                        // end of frame: a partial word at the gap is an error
                        low_cnt    <= GAP_SAT;
                        error      <= (bit_idx != 5'd0);
                        frame_done <= got_bit;
                        busy       <= 1'b0;
                        word_idx   <= '0;
                        bit_idx    <= '0;
                        got_bit    <= 1'b0;
                        gap_seen   <= 1'b1;
                    end else if (low_cnt != GAP_SAT) begin
                        low_cnt <= low_cnt + LOW_W'(1);
                    end
                end

                S_HIGH: begin
                    if (fall) begin
                        state <= S_LOW;
                        if (high_cnt >= MIN_H) begin
                            got_bit         <= 1'b1;
                            shift[bit_idx]  <= bit_val;
                            if (bit_idx == 5'd23) begin
                                bit_idx  <= '0;
                                word_idx <= sat_inc16(word_idx);
                                if ({1'b0, word_idx} < LEDS_W) begin
                                    color       <= {bit_val, shift[22:0]};
                                    address     <= word_idx;
                                    color_valid <= 1'b1;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 5'd1;
                            end
                        end
                    end else if (high_cnt >= MAX_H) begin
                        // stuck-high line: resynchronise on the next reset gap
                        error   <= 1'b1;
                        state   <= S_SYNC;
                        bit_idx <= '0;
                        low_cnt <= '0;
                    end else begin
                        high_cnt <= high_cnt + HIGH_W'(1);
                    end
                end

                default: state <= S_SYNC;
            endcase
        end
    end
endmodule
